// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan decoder.
// Contents:
//   seg_t         7-bit active-high segment vector {g,f,e,d,c,b,a}
//   SEG_*         segment patterns for the 16 hex glyphs and blank
//   scan_state_t  scan FSM states
//   hex_t         decoded glyph {valid, blank, nibble}
//   seg_to_hex()  pattern -> hex_t; valid=1 only for the 16 hex glyphs,
//                 blank=1 only for all-segments-off, both 0 otherwise
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b0111111;
  localparam seg_t SEG_1     = 7'b0000110;
  localparam seg_t SEG_2     = 7'b1011011;
  localparam seg_t SEG_3     = 7'b1001111;
  localparam seg_t SEG_4     = 7'b1100110;
  localparam seg_t SEG_5     = 7'b1101101;
  localparam seg_t SEG_6     = 7'b1111101;
  localparam seg_t SEG_7     = 7'b0000111;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1101111;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b1111100;
  localparam seg_t SEG_C     = 7'b0111001;
  localparam seg_t SEG_D     = 7'b1011110;
  localparam seg_t SEG_E     = 7'b1111001;
  localparam seg_t SEG_F     = 7'b1110001;
  localparam seg_t SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DWELL  = 2'd1,
    ACCEPT = 2'd2,
    HOLD   = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] nibble;
  } hex_t;

  function automatic hex_t seg_to_hex(seg_t seg);
    hex_t r;
    r       = '0;
    r.valid = 1'b1;
    case (seg)
      SEG_0:     r.nibble = 4'h0;
      SEG_1:     r.nibble = 4'h1;
      SEG_2:     r.nibble = 4'h2;
      SEG_3:     r.nibble = 4'h3;
      SEG_4:     r.nibble = 4'h4;
      SEG_5:     r.nibble = 4'h5;
      SEG_6:     r.nibble = 4'h6;
      SEG_7:     r.nibble = 4'h7;
      SEG_8:     r.nibble = 4'h8;
      SEG_9:     r.nibble = 4'h9;
      SEG_A:     r.nibble = 4'hA;
      SEG_B:     r.nibble = 4'hB;
      SEG_C:     r.nibble = 4'hC;
      SEG_D:     r.nibble = 4'hD;
      SEG_E:     r.nibble = 4'hE;
      SEG_F:     r.nibble = 4'hF;
      SEG_BLANK: begin
        r.valid = 1'b0;
        r.blank = 1'b1;
      end
      default:   r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational segment-pattern decoder (wraps seg_to_hex).
// Ports:
//   seg     in   7  active-high segments {g,f,e,d,c,b,a}
//   valid   out  1  pattern is one of the 16 hex glyphs
//   blank   out  1  all segments off
//   nibble  out  4  hex value (0 when not valid)
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic       blank,
  output logic [3:0] nibble
);

  hex_t dec;

  assign dec    = seg_to_hex(seg);
  assign valid  = dec.valid;
  assign blank  = dec.blank;
  assign nibble = dec.nibble;

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Monitors the multiplexed anode/cathode lines of a seven-segment display
// and rebuilds the hex value shown on it.
// Ports:
//   clk_in     in   1        system clock
//   rst_n_in   in   1        asynchronous active-low reset
//   an_in      in   N        digit anodes, active-low
//   cat_in     in   7        segment cathodes, active-low {g,f,e,d,c,b,a}
//   clear_in   in   1        drop partial frame, clear sticky errors
//   value_out  out  4N       last complete frame, digit k at [4k+3:4k]
//   blank_out  out  N        digit k was blank in last frame
//   err_out    out  N        sticky: digit k showed a non-hex pattern
//   valid_out  out  1        one-cycle pulse when value_out/blank_out update
//   state_out  out  2        current scan_state_t encoding (debug)
// Handshake: valid_out is a strobe with no ready; value_out/blank_out are
// stable from the pulse until the next pulse.
module seven_seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int MIN_DWELL  = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic [6:0]              cat_in,
  input  logic                    clear_in,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    valid_out,
  output logic [1:0]              state_out
);

  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
  localparam logic [DW-1:0] DWELL_ACC = DW'(MIN_DWELL - 1);

  // Two-flop synchronizers plus one extra stage used for change detection.
  // Idle value is all-high (display off, all segments off).
  logic [NUM_DIGITS-1:0] an_meta, an_sync, an_last;
  seg_t                  cat_meta, cat_sync, cat_last;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      an_meta  <= '1;
      an_sync  <= '1;
      an_last  <= '1;
      cat_meta <= '1;
      cat_sync <= '1;
      cat_last <= '1;
    end else begin
      an_meta  <= an_in;
      an_sync  <= an_meta;
      an_last  <= an_sync;
      cat_meta <= cat_in;
      cat_sync <= cat_meta;
      cat_last <= cat_sync;
    end
  end

  logic [NUM_DIGITS-1:0] an_act;
  logic                  one_hot, changed, stable;
  logic [DW-1:0]         dwell, dwell_next;

  assign an_act  = ~an_sync;
  assign one_hot = (an_act != '0) && ((an_act & (an_act - 1'b1)) == '0);
  assign changed = (an_sync != an_last) || (cat_sync != cat_last);
  assign stable  = one_hot && !changed;

  // dwell_next = number of consecutive samples the current pair has matched
  // its predecessor; reaching MIN_DWELL-1 means MIN_DWELL identical samples.
  always_comb begin
    dwell_next = '0;
    if (stable) dwell_next = (dwell == DWELL_MAX) ? dwell : dwell + 1'b1;
  end

  // In ACCEPT, an_last/cat_last still hold the pair that completed the dwell.
  logic [IW-1:0] acc_idx;
  always_comb begin
    acc_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_last[i]) acc_idx = IW'(i);
    end
  end

  logic       dec_valid, dec_blank;
  logic [3:0] dec_nibble;
  seg_t       acc_seg;

  assign acc_seg = ~cat_last;

  seg_pattern_decode u_decode (
    .seg    (acc_seg),
    .valid  (dec_valid),
    .blank  (dec_blank),
    .nibble (dec_nibble)
  );

  scan_state_t               state;
  logic [NUM_DIGITS-1:0]     seen;
  logic [4*NUM_DIGITS-1:0]   stage_value;
  logic [NUM_DIGITS-1:0]     stage_blank;

  assign state_out = state;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      dwell       <= '0;
      seen        <= '0;
      stage_value <= '0;
      stage_blank <= '0;
      value_out   <= '0;
      blank_out   <= '0;
      err_out     <= '0;
      valid_out   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (clear_in) begin
        // Overrides both a pending ACCEPT and a pending frame commit.
        state   <= IDLE;
        dwell   <= '0;
        seen    <= '0;
        err_out <= '0;
      end else begin
        dwell <= dwell_next;
        if (seen == '1) begin
          value_out <= stage_value;
          blank_out <= stage_blank;
          valid_out <= 1'b1;
          seen      <= '0;
        end
        case (state)
          IDLE:    if (one_hot) state <= DWELL;
          DWELL: begin
            if (!stable)                      state <= IDLE;
            else if (dwell_next == DWELL_ACC) state <= ACCEPT;
          end
          ACCEPT: begin
            stage_value[4*acc_idx +: 4] <= dec_valid ? dec_nibble : 4'h0;
            stage_blank[acc_idx]        <= dec_blank;
            if (!dec_valid && !dec_blank) err_out[acc_idx] <= 1'b1;
            seen[acc_idx] <= 1'b1;
            state         <= HOLD;
          end
          HOLD:    if (!stable) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
